// File: rtl/odd_parity_frame_ctrl.sv
// odd_parity_frame_ctrl
//   Receives a serial frame of DATA_BITS data bits (LSB first) followed by one
//   parity bit, checks for odd parity across data+parity, and reports the
//   result with a one-cycle frame_done pulse and a saturating error count.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start_i     in   1-cycle frame start strobe (also aborts a frame in progress)
//   bit_in_i    in   serial data/parity bit
//   bit_valid_i in   qualifies bit_in_i
//   busy_o      out  high while receiving data or waiting for the parity bit
//   frame_done_o out 1-cycle pulse when a frame completes
//   parity_ok_o out  result of the last completed frame
//   data_out_o  out  data of the last completed frame
//   err_count_o out  saturating count of failed frames
module odd_parity_frame_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 bit_in_i,
    input  logic                 bit_valid_i,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 parity_ok_o,
    output logic [DATA_BITS-1:0] data_out_o,
    output logic [CNT_W-1:0]     err_count_o
);

    localparam int CW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {IDLE, RECV, PAR, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 acc_q, acc_d;
    logic                 ok_q, ok_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pok_q, pok_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [CNT_W-1:0]     err_q, err_d;

    logic [DATA_BITS-1:0] nib_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            ok_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pok_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            ok_q    <= ok_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pok_q   <= pok_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        ok_d    = ok_q;
        done_d  = 1'b0;
        pok_d   = pok_q;
        data_d  = data_q;
        err_d   = err_q;
        nib_win = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                    acc_d   = 1'b0;
                end
            end
            RECV: begin
                if (start_i) begin
                    cnt_d   = '0;
                    shift_d = '0;
                    acc_d   = 1'b0;
                end else if (bit_valid_i) begin
                    // Shift register is cleared at frame start, so OR-in is a write.
                    shift_d = shift_q | (DATA_BITS'(bit_in_i) << cnt_q);
                    cnt_d   = cnt_q + 1'b1;
                    // Fold a completed nibble into the running parity.
                    if (cnt_q[1:0] == 2'b11) begin
                        nib_win = shift_d >> {cnt_q[CW-1:2], 2'b00};
                        acc_d   = acc_q ^ (^nib_win[3:0]);
                    end
                    if (cnt_q == CW'(DATA_BITS - 1)) begin
                        state_d = PAR;
                    end
                end
            end
            PAR: begin
                if (start_i) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                    acc_d   = 1'b0;
                end else if (bit_valid_i) begin
                    ok_d    = acc_q ^ bit_in_i;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d = 1'b1;
                pok_d  = ok_q;
                data_d = shift_q;
                if (!ok_q && (err_q != '1)) begin
                    err_d = err_q + 1'b1;
                end
                if (start_i) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                    acc_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RECV) || (state_d == PAR);
    end

    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign parity_ok_o  = pok_q;
    assign data_out_o   = data_q;
    assign err_count_o  = err_q;

endmodule
